// File: rtl/generic_write_arbiter.sv
// Round-robin arbiter funnelling N byte-addressed write requesters onto one
// byte-strobed memory write port; misaligned or oversize requests are rejected.
module generic_write_arbiter #(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 1024,
  parameter  int CHANNELS = 2,
  localparam int ADDR_W   = $clog2(DEPTH),
  localparam int BYTES    = WIDTH / 8,
  localparam int SHIFT    = $clog2(BYTES),
  localparam int OFF_W    = (SHIFT > 0) ? SHIFT : 1,
  localparam int MAX_SIZE = SHIFT,
  localparam int PTR_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          ch_write_valid,
  input  logic [CHANNELS*ADDR_W-1:0]   ch_write_address,
  input  logic [CHANNELS*WIDTH-1:0]    ch_write_data,
  input  logic [CHANNELS*2-1:0]        ch_write_size,
  output logic [CHANNELS-1:0]          ch_write_ready,
  output logic [CHANNELS-1:0]          ch_write_response,
  output logic [CHANNELS-1:0]          ch_write_error,
  output logic                         mem_write_valid,
  output logic [ADDR_W-SHIFT-1:0]      mem_write_address,
  output logic [WIDTH-1:0]             mem_write_data,
  output logic [BYTES-1:0]             mem_write_strobe,
  input  logic                         mem_write_ready
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [PTR_W-1:0]        r_rr;
  logic [PTR_W-1:0]        r_gnt;
  logic [ADDR_W-SHIFT-1:0] r_word;
  logic [OFF_W-1:0]        r_off;
  logic [1:0]              r_size;
  logic [WIDTH-1:0]        r_data;
  logic                    r_illegal;

  logic [ADDR_W-1:0]       w_addr_arr [CHANNELS];
  logic [WIDTH-1:0]        w_data_arr [CHANNELS];
  logic [1:0]              w_size_arr [CHANNELS];

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
      assign w_addr_arr[gi] = ch_write_address[gi*ADDR_W +: ADDR_W];
      assign w_data_arr[gi] = ch_write_data[gi*WIDTH +: WIDTH];
      assign w_size_arr[gi] = ch_write_size[gi*2 +: 2];
    end
  endgenerate

  // Two-pass priority: lowest valid channel at or above the pointer, else lowest overall.
  logic             w_any;
  logic             w_hi_found;
  logic [PTR_W-1:0] w_hi;
  logic [PTR_W-1:0] w_low;
  logic [PTR_W-1:0] w_gnt;

  always_comb begin
    w_any      = 1'b0;
    w_hi_found = 1'b0;
    w_hi       = '0;
    w_low      = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (ch_write_valid[c]) begin
        w_any = 1'b1;
        w_low = PTR_W'(c);
        if (c >= int'(r_rr)) begin
          w_hi_found = 1'b1;
          w_hi       = PTR_W'(c);
        end
      end
    end
    w_gnt = w_hi_found ? w_hi : w_low;
  end

  logic [ADDR_W-1:0] w_sel_addr;
  logic [1:0]        w_sel_size;
  logic [OFF_W-1:0]  w_sel_off;
  logic [3:0]        w_align_mask;
  logic              w_sel_legal;
  logic              w_accept;

  assign w_sel_addr = w_addr_arr[w_gnt];
  assign w_sel_size = w_size_arr[w_gnt];

  generate
    if (SHIFT > 0) begin : g_off
      assign w_sel_off = w_sel_addr[SHIFT-1:0];
    end else begin : g_no_off
      assign w_sel_off = '0;
    end
  endgenerate

  assign w_align_mask = (4'd1 << w_sel_size) - 4'd1;
  assign w_sel_legal  = (int'(w_sel_size) <= MAX_SIZE) &&
                        ((4'(w_sel_off) & w_align_mask) == 4'd0);
  assign w_accept     = (r_state == IDLE) && w_any;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_next = w_sel_legal ? ISSUE : RESP;
      ISSUE:   if (mem_write_ready) w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rr      <= '0;
      r_gnt     <= '0;
      r_word    <= '0;
      r_off     <= '0;
      r_size    <= '0;
      r_data    <= '0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_rr      <= (w_gnt == PTR_W'(CHANNELS - 1)) ? '0 : w_gnt + 1'b1;
      r_gnt     <= w_gnt;
      r_word    <= w_sel_addr[ADDR_W-1:SHIFT];
      r_off     <= w_sel_off;
      r_size    <= w_sel_size;
      r_data    <= w_data_arr[w_gnt];
      r_illegal <= !w_sel_legal;
    end
  end

  // Lanes covered by the access before shifting to the byte offset.
  logic [BYTES-1:0] w_lane_mask;
  logic [WIDTH-1:0] w_data_mask;

  always_comb begin
    w_lane_mask = '0;
    for (int b = 0; b < BYTES; b++) begin
      w_lane_mask[b] = (b < (int'(1) << r_size));
    end
  end

  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_dmask
      assign w_data_mask[gi*8 +: 8] = {8{w_lane_mask[gi]}};
    end
  endgenerate

  logic                w_issue;
  logic [CHANNELS-1:0] w_gnt_onehot;
  logic [CHANNELS-1:0] w_rsp_onehot;

  assign w_issue      = (r_state == ISSUE);
  assign w_gnt_onehot = CHANNELS'(1) << w_gnt;
  assign w_rsp_onehot = CHANNELS'(1) << r_gnt;

  assign ch_write_ready    = (w_accept && !reset) ? w_gnt_onehot : '0;
  assign ch_write_response = (r_state == RESP) ? w_rsp_onehot : '0;
  assign ch_write_error    = (r_state == RESP && r_illegal) ? w_rsp_onehot : '0;

  assign mem_write_valid   = w_issue;
  assign mem_write_address = w_issue ? r_word : '0;
  assign mem_write_data    = w_issue ? ((r_data & w_data_mask) << {r_off, 3'b000}) : '0;
  assign mem_write_strobe  = w_issue ? (w_lane_mask << r_off) : '0;

endmodule

// File: tb/tb_generic_write_arbiter.sv
// Directed bench for generic_write_arbiter (WIDTH=32, DEPTH=1024, CHANNELS=2)
// with hand-computed expectations for lanes, errors, rotation, stalls and reset.
module tb_generic_write_arbiter;

  localparam int WIDTH    = 32;
  localparam int DEPTH    = 1024;
  localparam int CHANNELS = 2;
  localparam int ADDR_W   = 10;

  logic                       clock = 1'b0;
  logic                       reset = 1'b1;
  logic [CHANNELS-1:0]        ch_write_valid = '0;
  logic [CHANNELS*ADDR_W-1:0] ch_write_address = '0;
  logic [CHANNELS*WIDTH-1:0]  ch_write_data = '0;
  logic [CHANNELS*2-1:0]      ch_write_size = '0;
  logic [CHANNELS-1:0]        ch_write_ready;
  logic [CHANNELS-1:0]        ch_write_response;
  logic [CHANNELS-1:0]        ch_write_error;
  logic                       mem_write_valid;
  logic [7:0]                 mem_write_address;
  logic [31:0]                mem_write_data;
  logic [3:0]                 mem_write_strobe;
  logic                       mem_write_ready = 1'b1;

  generic_write_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CHANNELS(CHANNELS)) dut (
    .clock             (clock),
    .reset             (reset),
    .ch_write_valid    (ch_write_valid),
    .ch_write_address  (ch_write_address),
    .ch_write_data     (ch_write_data),
    .ch_write_size     (ch_write_size),
    .ch_write_ready    (ch_write_ready),
    .ch_write_response (ch_write_response),
    .ch_write_error    (ch_write_error),
    .mem_write_valid   (mem_write_valid),
    .mem_write_address (mem_write_address),
    .mem_write_data    (mem_write_data),
    .mem_write_strobe  (mem_write_strobe),
    .mem_write_ready   (mem_write_ready)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [9:0] a, input logic [31:0] d, input logic [1:0] s);
    ch_write_address[ch*ADDR_W +: ADDR_W] = a;
    ch_write_data[ch*WIDTH +: WIDTH]      = d;
    ch_write_size[ch*2 +: 2]              = s;
  endtask

  // Presents one request, waits (bounded) for ready, and returns one cycle after acceptance.
  task automatic accept(input int ch, input logic [9:0] a, input logic [31:0] d, input logic [1:0] s);
    int n;
    set_ch(ch, a, d, s);
    ch_write_valid[ch] = 1'b1;
    #1;
    n = 0;
    while (!ch_write_ready[ch] && n < 20) begin
      tick();
      n++;
    end
    check_eq("accept_ready", 64'(ch_write_ready), 64'(1) << ch);
    $display("write ch%0d addr=%0h data=%0h size=%0d", ch, a, d, s);
    tick();
    ch_write_valid[ch] = 1'b0;
  endtask

  initial begin
    int gcnt [2];
    int rcnt [2];
    int order [8];
    int ng;

    // Reset state
    #1;
    check_eq("rst_ready", 64'(ch_write_ready), 64'h0);
    check_eq("rst_resp", 64'(ch_write_response), 64'h0);
    check_eq("rst_err", 64'(ch_write_error), 64'h0);
    check_eq("rst_mvalid", 64'(mem_write_valid), 64'h0);
    check_eq("rst_strobe", 64'(mem_write_strobe), 64'h0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check_eq("idle_ready", 64'(ch_write_ready), 64'h0);
    tick();

    // Single aligned word on ch0
    accept(0, 10'h010, 32'hDEADBEEF, 2'd2);
    check_eq("w_mvalid", 64'(mem_write_valid), 64'h1);
    check_eq("w_addr", 64'(mem_write_address), 64'h4);
    check_eq("w_strobe", 64'(mem_write_strobe), 64'hF);
    check_eq("w_data", 64'(mem_write_data), 64'hDEADBEEF);
    check_eq("w_resp_early", 64'(ch_write_response), 64'h0);
    tick();
    check_eq("w_resp", 64'(ch_write_response), 64'h1);
    check_eq("w_err", 64'(ch_write_error), 64'h0);
    check_eq("w_mvalid_off", 64'(mem_write_valid), 64'h0);
    tick();
    check_eq("w_resp_once", 64'(ch_write_response), 64'h0);

    // Byte in top lane on ch1
    accept(1, 10'h013, 32'h000000AB, 2'd0);
    check_eq("b_addr", 64'(mem_write_address), 64'h4);
    check_eq("b_strobe", 64'(mem_write_strobe), 64'h8);
    check_eq("b_data", 64'(mem_write_data), 64'hAB000000);
    tick();
    check_eq("b_resp", 64'(ch_write_response), 64'h2);
    tick();

    // Upper halfword on ch0
    accept(0, 10'h012, 32'h00001234, 2'd1);
    check_eq("h_strobe", 64'(mem_write_strobe), 64'hC);
    check_eq("h_data", 64'(mem_write_data), 64'h12340000);
    tick();
    check_eq("h_resp", 64'(ch_write_response), 64'h1);
    tick();

    // Lower halfword with junk above the size must be masked
    accept(1, 10'h000, 32'hFFFF1234, 2'd1);
    check_eq("hm_addr", 64'(mem_write_address), 64'h0);
    check_eq("hm_strobe", 64'(mem_write_strobe), 64'h3);
    check_eq("hm_data", 64'(mem_write_data), 64'h00001234);
    tick();
    tick();

    // Misaligned half -> error response at T+1, no memory write
    accept(0, 10'h011, 32'h00005555, 2'd1);
    check_eq("ma_mvalid", 64'(mem_write_valid), 64'h0);
    check_eq("ma_resp", 64'(ch_write_response), 64'h1);
    check_eq("ma_err", 64'(ch_write_error), 64'h1);
    tick();
    check_eq("ma_resp_once", 64'(ch_write_response), 64'h0);

    // Oversize (dword on a 32-bit port) -> error
    accept(1, 10'h000, 32'h12345678, 2'd3);
    check_eq("os_mvalid", 64'(mem_write_valid), 64'h0);
    check_eq("os_resp", 64'(ch_write_response), 64'h2);
    check_eq("os_err", 64'(ch_write_error), 64'h2);
    tick();

    // Contention: pointer is back at ch0, so grants alternate 0,1,0,1,...
    set_ch(0, 10'h000, 32'h0A0A0A0A, 2'd2);
    set_ch(1, 10'h004, 32'h0B0B0B0B, 2'd2);
    gcnt = '{0, 0};
    rcnt = '{0, 0};
    order = '{default: 9};
    ng = 0;
    ch_write_valid = 2'b11;
    for (int cyc = 0; cyc < 100 && (rcnt[0] + rcnt[1]) < 8; cyc++) begin
      #1;
      if (ch_write_ready != 2'b00 && ng < 8) begin
        order[ng] = ch_write_ready[1] ? 1 : 0;
        gcnt[order[ng]]++;
        ng++;
      end
      for (int c = 0; c < 2; c++) if (ch_write_response[c]) rcnt[c]++;
      @(posedge clock);
      #1;
      for (int c = 0; c < 2; c++) if (gcnt[c] >= 4) ch_write_valid[c] = 1'b0;
    end
    ch_write_valid = 2'b00;
    for (int i = 0; i < 8; i++) check_eq($sformatf("rr_grant%0d", i), 64'(order[i]), 64'(i % 2));
    check_eq("rr_resp_ch0", 64'(rcnt[0]), 64'd4);
    check_eq("rr_resp_ch1", 64'(rcnt[1]), 64'd4);
    $display("contention done: grants=%0d", ng);
    tick();

    // Backpressure: ISSUE outputs hold while memory is not ready
    mem_write_ready = 1'b0;
    accept(0, 10'h008, 32'hCAFEF00D, 2'd2);
    set_ch(0, 10'h3FF, 32'h11111111, 2'd0);
    for (int k = 0; k < 5; k++) begin
      check_eq("bp_mvalid", 64'(mem_write_valid), 64'h1);
      check_eq("bp_addr", 64'(mem_write_address), 64'h2);
      check_eq("bp_data", 64'(mem_write_data), 64'hCAFEF00D);
      check_eq("bp_strobe", 64'(mem_write_strobe), 64'hF);
      check_eq("bp_resp", 64'(ch_write_response), 64'h0);
      tick();
    end
    mem_write_ready = 1'b1;
    #1;
    check_eq("bp_resp_pre", 64'(ch_write_response), 64'h0);
    tick();
    check_eq("bp_resp", 64'(ch_write_response), 64'h1);
    check_eq("bp_err", 64'(ch_write_error), 64'h0);
    check_eq("bp_mvalid_off", 64'(mem_write_valid), 64'h0);
    tick();

    // Reset during ISSUE; pointer would otherwise favour ch1
    mem_write_ready = 1'b0;
    accept(0, 10'h020, 32'h11223344, 2'd2);
    check_eq("ar_mvalid_pre", 64'(mem_write_valid), 64'h1);
    set_ch(0, 10'h040, 32'h55667788, 2'd2);
    set_ch(1, 10'h044, 32'h99AABBCC, 2'd2);
    ch_write_valid = 2'b11;
    #1;
    reset = 1'b1;
    #1;
    check_eq("ar_mvalid", 64'(mem_write_valid), 64'h0);
    check_eq("ar_addr", 64'(mem_write_address), 64'h0);
    check_eq("ar_data", 64'(mem_write_data), 64'h0);
    check_eq("ar_strobe", 64'(mem_write_strobe), 64'h0);
    check_eq("ar_ready", 64'(ch_write_ready), 64'h0);
    check_eq("ar_resp", 64'(ch_write_response), 64'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    mem_write_ready = 1'b1;
    #1;
    check_eq("ar_grant_ch0", 64'(ch_write_ready), 64'h1);
    check_eq("ar_no_resp", 64'(ch_write_response), 64'h0);
    $display("write ch0 addr=40 data=55667788 size=2 (after reset)");
    tick();
    ch_write_valid = 2'b00;
    check_eq("ar_new_addr", 64'(mem_write_address), 64'h10);
    check_eq("ar_new_data", 64'(mem_write_data), 64'h55667788);
    check_eq("ar_no_resp2", 64'(ch_write_response), 64'h0);
    tick();
    check_eq("ar_new_resp", 64'(ch_write_response), 64'h1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
